// File: rtl/countdown_pkg.sv
// Shared types, segment patterns and helpers for the HH:MM:SS countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEC  = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_bcd);
        logic [6:0] w_seg;
        case (i_bcd)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

    // Returns {tens, units} when the pair is a legal value for the field, else 00.
    function automatic logic [7:0] validate_field(input logic [1:0] i_sel,
                                                  input logic [3:0] i_tens,
                                                  input logic [3:0] i_units);
        logic w_ok;
        if (i_sel == SEL_HOUR)
            w_ok = (i_units <= 4'd9) && ((i_tens < 4'd2) || ((i_tens == 4'd2) && (i_units <= 4'd3)));
        else
            w_ok = (i_tens <= 4'd5) && (i_units <= 4'd9);
        return w_ok ? {i_tens, i_units} : 8'h00;
    endfunction

endpackage

// File: rtl/countdown_timer_key.sv
// Key conditioner: two-flop synchroniser, level debouncer, falling-edge one-cycle pulse.
module key_conditioner #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_n,
    output logic o_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stablePrev;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_stable     <= 1'b1;
            r_stablePrev <= 1'b1;
        end else begin
            r_stablePrev <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_pulse = r_stablePrev & ~r_stable;

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS BCD countdown timer: key handling, run/pause FSM, 1 s prescaler and six-digit display.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] SW,
    input  logic       load_n,
    input  logic       run_n,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       running,
    output logic       done
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_h1, r_h0, r_m1, r_m0, r_s1, r_s0;
    logic [3:0]    w_h1n, w_h0n, w_m1n, w_m0n, w_s1n, w_s0n;
    logic          w_loadPulse;
    logic          w_runPulse;
    logic          w_tick;
    logic          w_timeZero;
    logic          w_lastSec;
    logic          w_doLoad;
    logic [7:0]    w_field;

    key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_loadKey (
        .clk     (clk),
        .reset_n (reset_n),
        .i_key_n (load_n),
        .o_pulse (w_loadPulse)
    );

    key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_runKey (
        .clk     (clk),
        .reset_n (reset_n),
        .i_key_n (run_n),
        .o_pulse (w_runPulse)
    );

    assign w_tick     = (r_state == RUN) && (r_presc == PRESC_MAX);
    assign w_timeZero = ({r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} == 24'h0);
    assign w_lastSec  = ({r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} == 24'h1);
    assign w_doLoad   = w_loadPulse && (r_state != RUN);
    assign w_field    = validate_field(SW[9:8], SW[7:4], SW[3:0]);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // A load pulse always wins over a simultaneous run pulse.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (!w_loadPulse && w_runPulse && !w_timeZero) w_nextState = RUN;
            RUN: begin
                if (w_tick && w_lastSec)              w_nextState = DONE;
                else if (w_runPulse && !w_loadPulse)  w_nextState = PAUSE;
            end
            PAUSE: begin
                if (w_loadPulse)     w_nextState = IDLE;
                else if (w_runPulse) w_nextState = RUN;
            end
            DONE:  if (w_loadPulse || w_runPulse) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        running = (r_state == RUN);
        done    = (r_state == DONE);
    end

    // One-second BCD borrow chain; only the digits that borrow change.
    always_comb begin
        w_h1n = r_h1;
        w_h0n = r_h0;
        w_m1n = r_m1;
        w_m0n = r_m0;
        w_s1n = r_s1;
        w_s0n = r_s0;
        if (r_s0 != 4'd0) begin
            w_s0n = r_s0 - 4'd1;
        end else begin
            w_s0n = 4'd9;
            if (r_s1 != 4'd0) begin
                w_s1n = r_s1 - 4'd1;
            end else begin
                w_s1n = 4'd5;
                if (r_m0 != 4'd0) begin
                    w_m0n = r_m0 - 4'd1;
                end else begin
                    w_m0n = 4'd9;
                    if (r_m1 != 4'd0) begin
                        w_m1n = r_m1 - 4'd1;
                    end else begin
                        w_m1n = 4'd5;
                        if (r_h0 != 4'd0) begin
                            w_h0n = r_h0 - 4'd1;
                        end else begin
                            w_h0n = 4'd9;
                            w_h1n = r_h1 - 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_h1    <= 4'd0;
            r_h0    <= 4'd0;
            r_m1    <= 4'd0;
            r_m0    <= 4'd0;
            r_s1    <= 4'd0;
            r_s0    <= 4'd0;
        end else begin
            if (r_state == RUN)
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            else if ((r_state == IDLE) || w_doLoad)
                r_presc <= '0;

            if (w_doLoad) begin
                case (SW[9:8])
                    SEL_SEC:  begin r_s1 <= w_field[7:4]; r_s0 <= w_field[3:0]; end
                    SEL_MIN:  begin r_m1 <= w_field[7:4]; r_m0 <= w_field[3:0]; end
                    SEL_HOUR: begin r_h1 <= w_field[7:4]; r_h0 <= w_field[3:0]; end
                    default:  ;
                endcase
            end else if (w_tick && !w_timeZero) begin
                r_h1 <= w_h1n;
                r_h0 <= w_h0n;
                r_m1 <= w_m1n;
                r_m0 <= w_m0n;
                r_s1 <= w_s1n;
                r_s0 <= w_s0n;
            end
        end
    end

    assign HEX5 = bcd_to_seg(r_h1);
    assign HEX4 = bcd_to_seg(r_h0);
    assign HEX3 = bcd_to_seg(r_m1);
    assign HEX2 = bcd_to_seg(r_m0);
    assign HEX1 = bcd_to_seg(r_s1);
    assign HEX0 = bcd_to_seg(r_s0);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed corner sequences, a load-validation table and random key traffic vs a seconds-based model.
module tb_countdown_timer;

    localparam int TB_CLK_HZ = 10;
    localparam int TB_DEB    = 4;
    localparam int KEY_LAT   = 2 + TB_DEB + 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] SW;
    logic       load_n;
    logic       run_n;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic       running;
    logic       done;

    int nTotal = 0;
    int nBad   = 0;

    int mSec, mPresc, mState;
    int cycleNo     = 0;
    int loadPressAt = -100;
    int runPressAt  = -100;

    logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        string      name;
        logic [9:0] sw;
        int         expSecs;
    } loadVec_t;

    loadVec_t vecs [10];

    countdown_timer #(.CLK_HZ(TB_CLK_HZ), .DEBOUNCE_CYC(TB_DEB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .SW      (SW),
        .load_n  (load_n),
        .run_n   (run_n),
        .HEX5    (HEX5),
        .HEX4    (HEX4),
        .HEX3    (HEX3),
        .HEX2    (HEX2),
        .HEX1    (HEX1),
        .HEX0    (HEX0),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] expHex(input int secs);
        int hh, mm, ss;
        hh = secs / 3600;
        mm = (secs / 60) % 60;
        ss = secs % 60;
        return {segTab[hh / 10], segTab[hh % 10], segTab[mm / 10],
                segTab[mm % 10], segTab[ss / 10], segTab[ss % 10]};
    endfunction

    function automatic int loadField(input int secs, input logic [9:0] sw);
        int hh, mm, ss, t, u, v;
        hh = secs / 3600;
        mm = (secs / 60) % 60;
        ss = secs % 60;
        t  = int'(sw[7:4]);
        u  = int'(sw[3:0]);
        v  = t * 10 + u;
        case (sw[9:8])
            2'b00: ss = (t <= 5 && u <= 9) ? v : 0;
            2'b01: mm = (t <= 5 && u <= 9) ? v : 0;
            2'b10: hh = (u <= 9 && v <= 23) ? v : 0;
            default: ;
        endcase
        return hh * 3600 + mm * 60 + ss;
    endfunction

    // Reference behaviour at the level of whole seconds and named modes, advanced once per rising edge.
    task automatic modelStep();
        bit lp, rp, tick;
        cycleNo++;
        lp = (cycleNo == loadPressAt + KEY_LAT);
        rp = (cycleNo == runPressAt + KEY_LAT);
        if (!reset_n) begin
            mSec = 0; mPresc = 0; mState = M_IDLE;
        end else begin
            case (mState)
                M_IDLE: begin
                    if (lp) mSec = loadField(mSec, SW);
                    else if (rp && mSec != 0) begin mState = M_RUN; mPresc = 0; end
                end
                M_RUN: begin
                    tick = (mPresc == TB_CLK_HZ - 1);
                    mPresc = tick ? 0 : mPresc + 1;
                    if (tick) mSec--;
                    if (tick && mSec == 0)  mState = M_DONE;
                    else if (rp && !lp)     mState = M_PAUSE;
                end
                M_PAUSE: begin
                    if (lp) begin mSec = loadField(mSec, SW); mPresc = 0; mState = M_IDLE; end
                    else if (rp) mState = M_RUN;
                end
                default: begin
                    if (lp) begin mSec = loadField(mSec, SW); mState = M_IDLE; end
                    else if (rp) mState = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic checkOutput();
        logic [41:0] act;
        act = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        nTotal++;
        if (act !== expHex(mSec) || running !== (mState == M_RUN) || done !== (mState == M_DONE)) begin
            nBad++;
            if (nBad <= 20)
                $display("[TB] FAIL model@%0d: hex=%h run=%b done=%b, required hex=%h run=%b done=%b",
                         cycleNo, act, running, done, expHex(mSec), mState == M_RUN, mState == M_DONE);
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic checkTime(input string name, input int secs);
        checkVal(name, 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(expHex(secs)));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic pressKey(input bit l, input bit r, input logic [9:0] sw);
        SW = sw;
        if (l) begin load_n = 1'b0; loadPressAt = cycleNo; end
        if (r) begin run_n  = 1'b0; runPressAt  = cycleNo; end
    endtask

    task automatic releaseKeys();
        load_n = 1'b1;
        run_n  = 1'b1;
    endtask

    task automatic applyStimulus(input bit l, input bit r, input logic [9:0] sw);
        pressKey(l, r, sw);
        repeat (8) stepCycle();
        releaseKeys();
        repeat (8) stepCycle();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        repeat (2) stepCycle();
        reset_n = 1'b1;
        stepCycle();
    endtask

    initial begin
        int cnt;
        logic [9:0] rsw;
        reset_n = 1'b0;
        load_n  = 1'b1;
        run_n   = 1'b1;
        SW      = '0;
        mSec = 0; mPresc = 0; mState = M_IDLE;

        vecs[0] = '{"sec 59",      {2'b00, 4'd5, 4'd9},  59};
        vecs[1] = '{"min 45",      {2'b01, 4'd4, 4'd5},  45 * 60 + 59};
        vecs[2] = '{"min 60 bad",  {2'b01, 4'd6, 4'd0},  59};
        vecs[3] = '{"hour 23",     {2'b10, 4'd2, 4'd3},  23 * 3600 + 59};
        vecs[4] = '{"hour 24 bad", {2'b10, 4'd2, 4'd4},  59};
        vecs[5] = '{"hour 19",     {2'b10, 4'd1, 4'd9},  19 * 3600 + 59};
        vecs[6] = '{"sel none",    {2'b11, 4'd3, 4'd3},  19 * 3600 + 59};
        vecs[7] = '{"sec 0A bad",  {2'b00, 4'd0, 4'd10}, 19 * 3600};
        vecs[8] = '{"min 37",      {2'b01, 4'd3, 4'd7},  19 * 3600 + 37 * 60};
        vecs[9] = '{"hour 30 bad", {2'b10, 4'd3, 4'd0},  37 * 60};

        doReset();
        checkTime("reset display", 0);
        checkVal("reset running", 64'(running), 0);

        $display("[TB] reset during RUN");
        applyStimulus(1, 0, {2'b00, 4'd0, 4'd7});
        pressKey(0, 1, SW);
        repeat (8) stepCycle();
        checkVal("run at 7", 64'(running), 1);
        checkTime("time 7", 7);
        reset_n = 1'b0;
        releaseKeys();
        stepCycle();
        checkVal("abort hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'({6{7'h40}}));
        checkVal("abort running", 64'(running), 0);
        checkVal("abort done", 64'(done), 0);
        reset_n = 1'b1;
        repeat (2) stepCycle();

        $display("[TB] load validation table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, vecs[i].sw);
            checkTime(vecs[i].name, vecs[i].expSecs);
        end

        $display("[TB] one hour countdown");
        doReset();
        applyStimulus(1, 0, 10'b10_0000_0001);
        checkTime("loaded 1h", 3600);
        applyStimulus(0, 1, SW);
        checkTime("1h before tick", 3600);
        checkVal("1h running", 64'(running), 1);
        stepCycle();
        checkTime("first tick", 3599);
        cnt = 0;
        while (done !== 1'b1 && cnt < 36100) begin
            stepCycle();
            cnt++;
        end
        checkVal("cycles to done", 64'(cnt), 35990);
        checkVal("done running", 64'(running), 0);
        checkTime("done display", 0);

        $display("[TB] pause and resume");
        applyStimulus(1, 0, {2'b00, 4'd0, 4'd5});
        checkVal("load from done", 64'(done), 0);
        applyStimulus(0, 1, SW);
        stepCycle();
        checkTime("after tick 1", 4);
        repeat (6) stepCycle();
        pressKey(0, 1, SW);
        repeat (7) stepCycle();
        checkTime("paused value", 3);
        checkVal("paused running", 64'(running), 0);
        stepCycle();
        releaseKeys();
        repeat (50) stepCycle();
        checkTime("held value", 3);
        pressKey(0, 1, SW);
        repeat (7) stepCycle();
        checkVal("resumed", 64'(running), 1);
        repeat (6) stepCycle();
        checkTime("before resume tick", 3);
        stepCycle();
        checkTime("resume tick", 2);
        releaseKeys();
        repeat (8) stepCycle();

        $display("[TB] edge cases");
        doReset();
        applyStimulus(0, 1, SW);
        checkVal("run at zero", 64'(running), 0);
        applyStimulus(1, 1, {2'b00, 4'd1, 4'd2});
        checkTime("load+run value", 12);
        checkVal("load+run running", 64'(running), 0);
        applyStimulus(0, 1, SW);
        stepCycle();
        checkTime("edge tick 1", 11);
        repeat (3) stepCycle();
        pressKey(0, 1, SW);
        repeat (7) stepCycle();
        checkTime("tick+run value", 10);
        checkVal("tick+run running", 64'(running), 0);
        checkVal("tick+run done", 64'(done), 0);
        repeat (10) stepCycle();
        checkTime("tick+run held", 10);
        releaseKeys();
        repeat (8) stepCycle();

        $display("[TB] debounce");
        for (int g = 0; g < 3; g++) begin
            run_n = 1'b0;
            repeat (3) stepCycle();
            run_n = 1'b1;
            repeat (8) stepCycle();
        end
        checkVal("glitch ignored", 64'(running), 0);
        checkTime("glitch time", 10);
        pressKey(0, 1, SW);
        cnt = 0;
        while (running !== 1'b1 && cnt < 20) begin
            stepCycle();
            cnt++;
        end
        checkVal("press latency", 64'(cnt), KEY_LAT);
        releaseKeys();
        repeat (8) stepCycle();

        $display("[TB] random traffic");
        doReset();
        for (int k = 0; k < 80; k++) begin
            rsw = {($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 6)), 4'($urandom_range(0, 11))};
            case ($urandom_range(0, 4))
                0, 1: applyStimulus(1, 0, rsw);
                2:    applyStimulus(0, 1, rsw);
                3:    applyStimulus(1, 1, rsw);
                default: repeat ($urandom_range(1, 60)) stepCycle();
            endcase
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
